// File: rtl/ps2_temp_capture_if.sv
// Byte-stream and commit-side signals between the PS/2 receiver, the capture
// block and the temperature-range decoder.
interface ps2_temp_capture_if;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic [7:0] DECENAS;
  logic [7:0] UNIDADES;
  logic       Bandera;
  logic       busy;
  logic [1:0] digits;

  modport master (
    output rx_done_tick, dout,
    input  DECENAS, UNIDADES, Bandera, busy, digits
  );

  modport slave (
    input  rx_done_tick, dout,
    output DECENAS, UNIDADES, Bandera, busy, digits
  );
endinterface

// File: rtl/ps2_temp_capture.sv
// Collects a two-digit temperature entry from PS/2 make-codes and presents it
// to the range decoder with a one-cycle Bandera strobe on Enter.
module ps2_temp_capture #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned TO_WIDTH       = 27
) (
  input logic              CLK,
  input logic              reset,
  ps2_temp_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_UNITS = 2'd1,
    WAIT_ENTER = 2'd2
  } state_e;

  localparam logic [7:0] K_ZERO  = 8'h45;
  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [7:0] K_BKSP  = 8'h66;
  localparam logic [7:0] K_ESC   = 8'h76;
  localparam logic [7:0] K_BRK   = 8'hF0;
  localparam logic [7:0] K_EXT   = 8'hE0;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  function automatic logic is_digit(input logic [7:0] code);
    case (code)
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
      8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46: is_digit = 1'b1;
      default:                           is_digit = 1'b0;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [7:0]          tens_q, tens_d;
  logic [7:0]          units_q, units_d;
  logic [7:0]          dec_q, dec_d;
  logic [7:0]          uni_q, uni_d;
  logic                band_q, band_d;
  logic                busy_q, busy_d;
  logic [1:0]          digits_q, digits_d;
  logic                brk_q, brk_d;
  logic                ext_q, ext_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;

  // State, buffers, committed outputs and timeout counter
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      tens_q   <= K_ZERO;
      units_q  <= K_ZERO;
      dec_q    <= K_ZERO;
      uni_q    <= K_ZERO;
      band_q   <= 1'b0;
      busy_q   <= 1'b0;
      digits_q <= 2'd0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tens_q   <= tens_d;
      units_q  <= units_d;
      dec_q    <= dec_d;
      uni_q    <= uni_d;
      band_q   <= band_d;
      busy_q   <= busy_d;
      digits_q <= digits_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      cnt_q    <= cnt_d;
    end
  end

  // Byte classification, entry FSM and timeout; a tick always wins over expiry
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    dec_d   = dec_q;
    uni_d   = uni_q;
    band_d  = 1'b0;
    brk_d   = brk_q;
    ext_d   = ext_q;
    cnt_d   = cnt_q;

    if (bus.rx_done_tick) begin
      cnt_d = '0;
      if (bus.dout == K_BRK) begin
        brk_d = 1'b1;
      end else if (bus.dout == K_EXT) begin
        ext_d = 1'b1;
      end else if (brk_q || ext_q) begin
        // Break codes and extended keys (keypad Enter included) are dropped
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (is_digit(bus.dout)) begin
              tens_d  = bus.dout;
              state_d = WAIT_UNITS;
            end else begin
              state_d = IDLE;
            end
          end
          WAIT_UNITS: begin
            if (is_digit(bus.dout)) begin
              units_d = bus.dout;
              state_d = WAIT_ENTER;
            end else if (bus.dout == K_BKSP || bus.dout == K_ESC) begin
              tens_d  = K_ZERO;
              units_d = K_ZERO;
              state_d = IDLE;
            end else if (bus.dout == K_ENTER) begin
              dec_d   = K_ZERO;
              uni_d   = tens_q;
              band_d  = 1'b1;
              tens_d  = K_ZERO;
              units_d = K_ZERO;
              state_d = IDLE;
            end else begin
              state_d = WAIT_UNITS;
            end
          end
          WAIT_ENTER: begin
            if (bus.dout == K_BKSP) begin
              units_d = K_ZERO;
              state_d = WAIT_UNITS;
            end else if (bus.dout == K_ESC) begin
              tens_d  = K_ZERO;
              units_d = K_ZERO;
              state_d = IDLE;
            end else if (bus.dout == K_ENTER) begin
              dec_d   = tens_q;
              uni_d   = units_q;
              band_d  = 1'b1;
              tens_d  = K_ZERO;
              units_d = K_ZERO;
              state_d = IDLE;
            end else begin
              state_d = WAIT_ENTER;
            end
          end
          default: begin
            tens_d  = K_ZERO;
            units_d = K_ZERO;
            state_d = IDLE;
          end
        endcase
      end
    end else if (state_q != IDLE) begin
      if (cnt_q == TO_LAST) begin
        state_d = IDLE;
        tens_d  = K_ZERO;
        units_d = K_ZERO;
        brk_d   = 1'b0;
        ext_d   = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end

    if (state_d == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_d;
    end

    busy_d = (state_d != IDLE);
    case (state_d)
      IDLE:       digits_d = 2'd0;
      WAIT_UNITS: digits_d = 2'd1;
      WAIT_ENTER: digits_d = 2'd2;
      default:    digits_d = 2'd0;
    endcase
  end

  assign bus.DECENAS  = dec_q;
  assign bus.UNIDADES = uni_q;
  assign bus.Bandera  = band_q;
  assign bus.busy     = busy_q;
  assign bus.digits   = digits_q;

endmodule

// File: tb/tb_ps2_temp_capture.sv
// Directed and randomized checks of ps2_temp_capture against a queue-based
// model of the digit entry.
module tb_ps2_temp_capture;
  localparam int TOC = 20;

  logic CLK = 1'b0;
  logic reset;
  ps2_temp_capture_if bus();

  ps2_temp_capture #(.TIMEOUT_CYCLES(TOC), .TO_WIDTH(5)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: the entry is a queue of buffered make-codes
  logic [7:0] m_q[$];
  bit         m_skip;
  int         m_idle;
  logic [7:0] m_dec, m_uni;
  bit         m_band;
  int obs_pulses, exp_pulses, pulse_skew;

  function automatic bit is_dig(input logic [7:0] b);
    logic [7:0] digs [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    foreach (digs[k]) if (digs[k] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model(input bit rs, input bit tk, input logic [7:0] b);
    m_band = 1'b0;
    if (rs) begin
      m_q.delete(); m_skip = 0; m_idle = 0; m_dec = 8'h45; m_uni = 8'h45;
      return;
    end
    if (!tk) begin
      if (m_q.size() != 0) begin
        if (m_idle == TOC - 1) begin
          m_q.delete(); m_skip = 0;
        end else m_idle++;
      end
    end else begin
      m_idle = 0;
      if (b == 8'hF0 || b == 8'hE0) m_skip = 1;
      else if (m_skip) m_skip = 0;
      else if (is_dig(b)) begin
        if (m_q.size() < 2) m_q.push_back(b);
      end else if (b == 8'h5A) begin
        if (m_q.size() == 2) begin m_dec = m_q[0]; m_uni = m_q[1]; m_band = 1; end
        else if (m_q.size() == 1) begin m_dec = 8'h45; m_uni = m_q[0]; m_band = 1; end
        m_q.delete();
      end else if (b == 8'h66) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
      end else if (b == 8'h76) m_q.delete();
    end
    if (m_q.size() == 0) m_idle = 0;
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge
  task automatic step(input bit rs, input bit tk, input logic [7:0] b);
    reset = rs; bus.rx_done_tick = tk; bus.dout = b;
    model(rs, tk, b);
    @(posedge CLK); #1;
    reset = 1'b0; bus.rx_done_tick = 1'b0;
    if (bus.Bandera === 1'b1) obs_pulses++;
    if (m_band) exp_pulses++;
    if (bus.Bandera !== m_band) pulse_skew++;
  endtask

  task automatic play(input logic [7:0] seq[$]);
    obs_pulses = 0; exp_pulses = 0; pulse_skew = 0;
    foreach (seq[i]) begin
      step(0, 1, seq[i]);
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
    end
  endtask

  task automatic test_reset();
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    n_cmp++; if (bus.DECENAS !== 8'h45) begin n_fail++; $display("FAIL reset_dec got %h exp 45", bus.DECENAS); end
    n_cmp++; if (bus.UNIDADES !== 8'h45) begin n_fail++; $display("FAIL reset_uni got %h exp 45", bus.UNIDADES); end
    n_cmp++; if ({bus.Bandera, bus.busy, bus.digits} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_flags got %b exp 0000", {bus.Bandera, bus.busy, bus.digits}); end
  endtask

  task automatic test_two_digit();
    logic [7:0] seq [9] = '{8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26, 8'h5A, 8'hF0, 8'h5A};
    obs_pulses = 0; exp_pulses = 0; pulse_skew = 0;
    foreach (seq[i]) begin
      step(0, 1, seq[i]);
      n_cmp++; if (bus.digits !== 2'(m_q.size()) || bus.busy !== (m_q.size() != 0)) begin n_fail++;
        $display("FAIL two_digit_progress byte %0d got d=%0d b=%b exp d=%0d", i, bus.digits, bus.busy, m_q.size()); end
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
    end
    n_cmp++; if (bus.DECENAS !== 8'h1E || bus.UNIDADES !== 8'h26) begin n_fail++;
      $display("FAIL two_digit_value got %h/%h exp 1e/26", bus.DECENAS, bus.UNIDADES); end
    n_cmp++; if (obs_pulses !== 1 || pulse_skew !== 0) begin n_fail++;
      $display("FAIL two_digit_pulse got %0d pulses skew %0d exp 1/0", obs_pulses, pulse_skew); end
  endtask

  task automatic test_single_digit();
    play('{8'h2E, 8'h5A});
    n_cmp++; if (bus.DECENAS !== 8'h45 || bus.UNIDADES !== 8'h2E || obs_pulses !== 1 || pulse_skew !== 0) begin n_fail++;
      $display("FAIL single_digit got %h/%h pulses %0d skew %0d exp 45/2e 1 0", bus.DECENAS, bus.UNIDADES, obs_pulses, pulse_skew); end
    play('{8'h5A});
    n_cmp++; if (bus.DECENAS !== 8'h45 || bus.UNIDADES !== 8'h2E || obs_pulses !== 0) begin n_fail++;
      $display("FAIL idle_enter got %h/%h pulses %0d exp 45/2e 0", bus.DECENAS, bus.UNIDADES, obs_pulses); end
  endtask

  task automatic test_bksp_esc();
    play('{8'h16, 8'h25, 8'h66, 8'h36, 8'h5A});
    n_cmp++; if (bus.DECENAS !== 8'h16 || bus.UNIDADES !== 8'h36 || obs_pulses !== 1 || pulse_skew !== 0) begin n_fail++;
      $display("FAIL backspace got %h/%h pulses %0d exp 16/36 1", bus.DECENAS, bus.UNIDADES, obs_pulses); end
    play('{8'h16, 8'h76, 8'h5A});
    n_cmp++; if (bus.DECENAS !== 8'h16 || bus.UNIDADES !== 8'h36 || obs_pulses !== 0 || bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL escape got %h/%h pulses %0d busy %b exp 16/36 0 0", bus.DECENAS, bus.UNIDADES, obs_pulses, bus.busy); end
  endtask

  task automatic test_ext_overflow();
    play('{8'h16, 8'h25, 8'hE0, 8'h5A});
    n_cmp++; if (obs_pulses !== 0 || bus.digits !== 2'd2) begin n_fail++;
      $display("FAIL keypad_enter got pulses %0d digits %0d exp 0 2", obs_pulses, bus.digits); end
    play('{8'h3E});
    n_cmp++; if (bus.digits !== 2'd2) begin n_fail++; $display("FAIL third_digit got digits %0d exp 2", bus.digits); end
    play('{8'h5A});
    n_cmp++; if (bus.DECENAS !== 8'h16 || bus.UNIDADES !== 8'h25 || obs_pulses !== 1 || pulse_skew !== 0) begin n_fail++;
      $display("FAIL overflow_commit got %h/%h pulses %0d exp 16/25 1", bus.DECENAS, bus.UNIDADES, obs_pulses); end
  endtask

  task automatic test_timeout();
    step(0, 1, 8'h16);
    repeat (TOC - 1) step(0, 0, 8'h00);
    n_cmp++; if (bus.busy !== 1'b1 || bus.digits !== 2'd1) begin n_fail++;
      $display("FAIL timeout_before got busy %b digits %0d exp 1 1", bus.busy, bus.digits); end
    step(0, 0, 8'h00);
    n_cmp++; if (bus.busy !== 1'b0 || bus.digits !== 2'd0) begin n_fail++;
      $display("FAIL timeout_expire got busy %b digits %0d exp 0 0", bus.busy, bus.digits); end
    step(0, 1, 8'h16);
    repeat (TOC - 1) step(0, 0, 8'h00);
    step(0, 1, 8'h1E);
    n_cmp++; if (bus.busy !== 1'b1 || bus.digits !== 2'd2) begin n_fail++;
      $display("FAIL timeout_tick_wins got busy %b digits %0d exp 1 2", bus.busy, bus.digits); end
    play('{8'h5A});
    n_cmp++; if (bus.DECENAS !== 8'h16 || bus.UNIDADES !== 8'h1E || obs_pulses !== 1) begin n_fail++;
      $display("FAIL timeout_commit got %h/%h pulses %0d exp 16/1e 1", bus.DECENAS, bus.UNIDADES, obs_pulses); end
  endtask

  task automatic test_reset_mid_entry();
    play('{8'h16, 8'h25});
    step(1, 0, 8'h00);
    n_cmp++; if (bus.busy !== 1'b0 || bus.DECENAS !== 8'h45 || bus.UNIDADES !== 8'h45 || bus.Bandera !== 1'b0) begin n_fail++;
      $display("FAIL reset_mid got busy %b %h/%h band %b exp 0 45/45 0", bus.busy, bus.DECENAS, bus.UNIDADES, bus.Bandera); end
    play('{8'h5A});
    n_cmp++; if (obs_pulses !== 0) begin n_fail++; $display("FAIL reset_mid_enter got pulses %0d exp 0", obs_pulses); end
  endtask

  task automatic test_random();
    logic [7:0] pool [15] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                              8'h5A, 8'h66, 8'h76, 8'hF0, 8'hE0};
    logic [7:0] b;
    int gap;
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 17);
      b = (r < 15) ? pool[r] : ((r == 15) ? 8'h5A : 8'($urandom_range(0, 255)));
      gap = ($urandom_range(0, 15) == 0) ? $urandom_range(TOC - 2, TOC + 1) : $urandom_range(0, 3);
      for (int g = 0; g <= gap; g++) begin
        step(0, (g == 0), b);
        n_cmp++;
        if (bus.DECENAS !== m_dec || bus.UNIDADES !== m_uni || bus.Bandera !== m_band ||
            bus.busy !== (m_q.size() != 0) || bus.digits !== 2'(m_q.size())) begin
          n_fail++;
          $display("FAIL random_cycle byte %0d got %h/%h b%b busy%b d%0d exp %h/%h b%b d%0d", i,
                   bus.DECENAS, bus.UNIDADES, bus.Bandera, bus.busy, bus.digits,
                   m_dec, m_uni, m_band, m_q.size());
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; bus.rx_done_tick = 1'b0; bus.dout = 8'h00;
    test_reset();
    test_two_digit();
    test_single_digit();
    test_bksp_esc();
    test_ext_overflow();
    test_timeout();
    test_reset_mid_entry();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_temp_capture.md
Name: ps2_temp_capture

Overview:
- Sits directly upstream of the temperature-range decoder, between the PS/2 byte receiver and the decoder's DECENAS/UNIDADES/Bandera inputs.
- Parses the PS/2 scan-code stream and collects a two-digit temperature entry (tens, then units). Supports backspace, escape and a timeout.
- On Enter it presents the two digit make-codes and pulses Bandera for one cycle, so the decoder loads the value.

Parameters:
- TIMEOUT_CYCLES, 100_000_000, idle cycles allowed mid-entry before the entry is aborted (1 s at 100 MHz).
- TO_WIDTH, 27, width of the timeout counter; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_done_tick  in  1  one-cycle strobe: a new scan-code byte is valid on dout.
- dout  in  8  scan-code byte from the PS/2 receiver.
- DECENAS  out  8  committed tens-digit make-code.
- UNIDADES  out  8  committed units-digit make-code.
- Bandera  out  1  one-cycle commit pulse.
- busy  out  1  high while an entry is in progress (state is not IDLE).
- digits  out  2  number of digits currently buffered (0..2).

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-high.
- Reset values: DECENAS=8'h45, UNIDADES=8'h45, Bandera=0, busy=0, digits=0, state=IDLE, internal buffers=8'h45, prefix flags cleared, timeout counter=0. A reset mid-entry discards the entry with no Bandera.
- Byte classes, evaluated only when rx_done_tick=1:
  - Digit: 45,16,1E,26,25,2E,36,3D,3E,46 (0..9).
  - ENTER: 5A.
  - BKSP: 66.
  - ESC: 76.
  - Prefixes: F0 (break), E0 (extended).
  - Anything else: ignored.
- Prefix handling:
  - F0 sets brk; the next non-prefix byte is discarded and brk is cleared.
  - E0 sets ext; the next non-prefix byte is discarded. E0 F0 xx is fully discarded.
  - Prefix bytes themselves never change state.
- States: IDLE, WAIT_UNITS, WAIT_ENTER. Transitions on an accepted make-code:
  - IDLE:
    - digit -> tens_buf=code, WAIT_UNITS.
    - ENTER/BKSP/ESC -> stay in IDLE.
  - WAIT_UNITS:
    - digit -> units_buf=code, WAIT_ENTER.
    - BKSP -> IDLE, tens_buf=45.
    - ESC -> IDLE, buffers=45.
    - ENTER -> commit single digit: DECENAS=45, UNIDADES=tens_buf; then IDLE.
  - WAIT_ENTER:
    - digit -> ignored (two digits maximum).
    - BKSP -> WAIT_UNITS, units_buf=45.
    - ESC -> IDLE, buffers=45.
    - ENTER -> commit: DECENAS=tens_buf, UNIDADES=units_buf; then IDLE.
- Commit timing:
  - ENTER tick at cycle N -> DECENAS/UNIDADES updated and Bandera=1 at cycle N+1, both registered. Data is stable whenever Bandera=1.
  - Bandera returns to 0 at N+2.
  - DECENAS/UNIDADES hold their value until the next commit and never change outside a commit.
  - After a commit, buffers reset to 45 and digits=0.
- digits output: IDLE=0, WAIT_UNITS=1, WAIT_ENTER=2, registered with state.
- Timeout:
  - The counter runs only in WAIT_UNITS/WAIT_ENTER and clears on every rx_done_tick (any byte, prefixes included) and on entry to IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 without a tick -> IDLE, buffers=45, prefix flags cleared, no Bandera.
- Simultaneous events:
  - rx_done_tick in the same cycle as timeout expiry: the byte is processed and the timeout is not applied.
  - reset has priority over everything.
- No back-pressure. A byte arriving in the cycle Bandera is high is processed normally.

Test Plan:
- Reset, then bytes 1E,F0,1E,26,F0,26,5A,F0,5A (each one tick, gaps ≥2 cycles) -> one Bandera pulse exactly 1 cycle after the 5A make tick, with DECENAS=1E, UNIDADES=26 (decoder sees 23); busy and digits step 0→1→2→0.
- Bytes 2E,5A -> Bandera pulse with DECENAS=45, UNIDADES=2E; bytes 5A in IDLE -> no pulse, outputs unchanged.
- Bytes 16,25,66,36,5A -> DECENAS=16, UNIDADES=36. Bytes 16,76,5A -> no Bandera, and DECENAS/UNIDADES keep their prior values.
- Bytes E0,5A (keypad Enter) after 16,25 -> discarded, no pulse, digits=2. Bytes 16,25,3E -> digits stays 2 and UNIDADES=25 on the later commit.
- TIMEOUT_CYCLES=20: byte 16, then 19 idle cycles -> busy still 1 and digits=1; cycle 20 -> busy=0, digits=0. Repeat with a tick exactly on the expiry cycle -> entry continues.
- Reset asserted in WAIT_ENTER -> next cycle busy=0, DECENAS=UNIDADES=45, Bandera=0. A subsequent 5A produces no pulse.
